// File: rtl/clock_period_meter_pkg.sv
// clock_period_meter_pkg: shared FSM state encoding for the clock period meter.
`default_nettype none

package clock_period_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_STALL   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/clock_period_meter_sync_edge_detect.sv
// clock_period_meter_sync_edge_detect: synchronizes the measured clock and flags its edges.
`default_nettype none

module clock_period_meter_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_in,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow clock in system-clock
// cycles, and flags a stall when no rising edge arrives for 2^WIDTH-1 cycles.
`default_nettype none

module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic sync_w;
  logic rise_w;
  logic fall_w;

  clock_period_meter_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_in (clk_in),
    .sync_o (sync_w),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    stalled_d   = stalled_q;

    // Disable takes priority over any edge seen in the same cycle.
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      stalled_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (!sync_w) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (rise_w) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // A rise on the saturating cycle still closes the period.
          if (rise_w) begin
            period_d    = cnt_q;
            high_time_d = hi_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
          end else begin
            if (fall_w) hi_d = cnt_q;
            if (cnt_q == CNT_MAX) begin
              state_d   = ST_STALL;
              stalled_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_STALL: begin
          if (rise_w) begin
            state_d   = ST_MEASURE;
            cnt_d     = CNT_ONE;
            stalled_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed scenarios for clock_period_meter (WIDTH=8 so stalls are quick).
`default_nettype none

module tb_clock_period_meter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_in;
  logic       enable;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       period_valid;
  logic       stalled;

  int n_checks = 0;
  int n_pass   = 0;

  clock_period_meter #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_in      (clk_in),
    .enable      (enable),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  // Drive clk_in just after a rising edge, then return at the falling edge to sample.
  task automatic tick(input logic v);
    @(posedge clk);
    #1 clk_in = v;
    @(negedge clk);
  endtask

  task automatic restart();
    @(posedge clk);
    #1;
    enable = 1'b0;
    clk_in = 1'b0;
    repeat (6) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    clk_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({period, high_time, period_valid, stalled} !== 18'd0)
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b s=%b exp all 0", period, high_time, period_valid, stalled);
    else n_pass++;
    reset_n = 1'b1;
    repeat (4) tick(1'b0);
    n_checks++;
    if (period_valid !== 1'b0 || stalled !== 1'b0)
      $display("FAIL reset_idle: got v=%b s=%b exp 0 0", period_valid, stalled);
    else n_pass++;
  endtask

  // Periodic waveform: lo cycles low, then hi cycles high. Valid follows every rise
  // except the first by the fixed 3-cycle detect latency.
  task automatic run_wave(input string name, input int lo, input int hi, input int ncyc);
    int   p         = lo + hi;
    int   last_rise = -10;
    int   ord       = 0;
    logic pv        = 1'b0;
    logic v;
    logic ev;
    restart();
    for (int i = 0; i < ncyc; i++) begin
      v = ((i % p) >= lo);
      tick(v);
      if (v && !pv) begin
        last_rise = i;
        ord++;
      end
      pv = v;
      ev = (i == last_rise + 3) && (ord >= 2);
      n_checks++;
      if (period_valid !== ev)
        $display("FAIL %s_valid i=%0d: got %b exp %b", name, i, period_valid, ev);
      else n_pass++;
      if (ev) begin
        n_checks++;
        if (period !== 8'(p)) $display("FAIL %s_period i=%0d: got %0d exp %0d", name, i, period, p);
        else n_pass++;
        n_checks++;
        if (high_time !== 8'(hi)) $display("FAIL %s_high i=%0d: got %0d exp %0d", name, i, high_time, hi);
        else n_pass++;
      end
    end
    n_checks++;
    if (stalled !== 1'b0) $display("FAIL %s_stalled: got %b exp 0", name, stalled);
    else n_pass++;
  endtask

  task automatic test_divider();
    run_wave("div25", 25, 25, 230);
  endtask

  task automatic test_duty();
    run_wave("h10l30", 30, 10, 170);
  endtask

  task automatic test_max_boundary();
    run_wave("max255", 245, 10, 510);
  endtask

  task automatic test_stall();
    logic v;
    logic ev, es;
    restart();
    for (int i = 0; i <= 390; i++) begin
      if (i < 80)       v = ((i % 40) >= 30);
      else if (i < 340) v = 1'b0;
      else              v = (((i - 340) % 40) < 10);
      tick(v);
      ev = (i == 73) || (i == 383);
      es = (i >= 328) && (i <= 342);
      n_checks++;
      if (period_valid !== ev) $display("FAIL stall_valid i=%0d: got %b exp %b", i, period_valid, ev);
      else n_pass++;
      n_checks++;
      if (stalled !== es) $display("FAIL stall_flag i=%0d: got %b exp %b", i, stalled, es);
      else n_pass++;
      if (i == 330 || i == 383) begin
        n_checks++;
        if (period !== 8'd40 || high_time !== 8'd10)
          $display("FAIL stall_hold i=%0d: got p=%0d h=%0d exp p=40 h=10", i, period, high_time);
        else n_pass++;
      end
    end
  endtask

  task automatic test_arm();
    logic v;
    logic ev;
    @(posedge clk);
    #1;
    enable = 1'b0;
    clk_in = 1'b1;
    repeat (6) @(posedge clk);
    #1 enable = 1'b1;
    for (int i = 0; i <= 80; i++) begin
      if (i < 20)      v = 1'b1;
      else if (i < 30) v = 1'b0;
      else if (i < 40) v = 1'b1;
      else if (i < 70) v = 1'b0;
      else             v = 1'b1;
      tick(v);
      ev = (i == 73);
      n_checks++;
      if (period_valid !== ev) $display("FAIL arm_valid i=%0d: got %b exp %b", i, period_valid, ev);
      else n_pass++;
      if (ev) begin
        n_checks++;
        if (period !== 8'd40 || high_time !== 8'd10)
          $display("FAIL arm_values: got p=%0d h=%0d exp p=40 h=10", period, high_time);
        else n_pass++;
      end
    end
  endtask

  task automatic test_enable_drop();
    logic ev;
    restart();
    for (int i = 0; i <= 200; i++) begin
      tick((i % 40) >= 30);
      ev = (i == 73) || (i == 193);
      n_checks++;
      if (period_valid !== ev) $display("FAIL endrop_valid i=%0d: got %b exp %b", i, period_valid, ev);
      else n_pass++;
      if (i == 113 || i == 130 || i == 193) begin
        n_checks++;
        if (period !== 8'd40 || high_time !== 8'd10 || stalled !== 1'b0)
          $display("FAIL endrop_values i=%0d: got p=%0d h=%0d s=%b exp p=40 h=10 s=0", i, period, high_time, stalled);
        else n_pass++;
      end
      // Disable lands on the same cycle the rise from i=110 is detected.
      if (i == 112) enable = 1'b0;
      if (i == 134) enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    logic ev;
    restart();
    for (int i = 0; i <= 160; i++) begin
      tick((i % 40) >= 30);
      ev = (i == 73) || (i == 153);
      n_checks++;
      if (period_valid !== ev) $display("FAIL areset_valid i=%0d: got %b exp %b", i, period_valid, ev);
      else n_pass++;
      if (i == 90) begin
        n_checks++;
        if (period !== 8'd40) $display("FAIL areset_before: got p=%0d exp 40", period);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({period, high_time, period_valid, stalled} !== 18'd0)
          $display("FAIL areset_immediate: got p=%0d h=%0d v=%b s=%b exp all 0", period, high_time, period_valid, stalled);
        else n_pass++;
      end
      if (i == 94) reset_n = 1'b1;
      if (i == 153) begin
        n_checks++;
        if (period !== 8'd40 || high_time !== 8'd10)
          $display("FAIL areset_after: got p=%0d h=%0d exp p=40 h=10", period, high_time);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_duty();
    test_stall();
    test_max_boundary();
    test_arm();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
